ifu_fetch: RTL

- Instruction fetch stage; sits directly upstream of decode and the immediate extender.
- Owns the PC and issues one word read at a time to instruction memory over a valid/ready request plus response-valid interface.
- Presents {instr, pc, err} to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) from execute and discards any stale in-flight response.

---
 rtl/ifu_fetch_pkg.sv | 13 +
 rtl/ifu_pc_reg.sv | 38 +++
 rtl/ifu_fetch.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: async reset, +4 advance, redirect load (redirect wins).
module ifu_pc_reg
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, output held for decode,
// redirects squash in-flight responses via the discard flag.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_err
);

    fetch_state_e    state_q, state_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] pc;
    logic            pc_inc;
    logic            misaligned;
    logic            req_fire;

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i         (clk),
        .rst_i         (rst),
        .inc_i         (pc_inc),
        .redirect_i    (redirect_valid),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc)
    );

    assign misaligned     = (pc[1:0] != 2'b00);
    // Gated by rst so the request drops combinationally during reset.
    assign imem_req_valid = (state_q == S_REQ) && !misaligned && !rst;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        instr_d   = instr_q;
        opc_d     = opc_q;
        err_d     = err_q;
        pc_inc    = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    if (req_fire) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end else if (misaligned) begin
                    state_d = S_HOLD;
                    instr_d = NOP_INSTR;
                    opc_d   = pc;
                    err_d   = 1'b1;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    if (imem_resp_valid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (discard_q) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        instr_d = imem_resp_data;
                        opc_d   = pc;
                        err_d   = imem_resp_err;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (out_ready) begin
                    state_d = S_REQ;
                    pc_inc  = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            discard_q <= 1'b0;
            instr_q   <= '0;
            opc_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            instr_q   <= instr_d;
            opc_q     <= opc_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign out_err   = err_q;

endmodule
